// File: rtl/alu_pkg.sv
// alu_pkg: shared op and state encodings for the sequential shift/rotate unit
package alu_pkg;
  localparam logic [2:0] SHR  = 3'b000;
  localparam logic [2:0] SHRA = 3'b001;
  localparam logic [2:0] SHL  = 3'b010;
  localparam logic [2:0] ROR  = 3'b011;
  localparam logic [2:0] ROL  = 3'b100;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/shift_step.sv
// shift_step: combinational shift/rotate of value by k positions (k may equal WIDTH)
module shift_step import alu_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int KW    = 6
) (
  input  logic [WIDTH-1:0] value,
  input  logic [2:0]       op,
  input  logic [KW-1:0]    k,
  input  logic             fill,
  output logic [WIDTH-1:0] res
);
  logic [2*WIDTH-1:0] rdbl, ldbl;
  // double-width windows let a full-width shift drain cleanly into the fill
  always_comb begin
    rdbl = (op == ROR ? {value, value} : {{WIDTH{fill}}, value}) >> k;
    ldbl = (op == ROL ? {value, value} : {value, {WIDTH{1'b0}}}) << k;
    res  = (op == SHL || op == ROL) ? ldbl[2*WIDTH-1:WIDTH] : rdbl[WIDTH-1:0];
  end
endmodule

// File: rtl/alu_shift_seq.sv
// alu_shift_seq: multi-cycle shift/rotate unit with start/busy/done handshake
module alu_shift_seq import alu_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [31:0]      shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  localparam int LW = $clog2(WIDTH);
  state_t state, state_n;
  logic [CNT_W-1:0] rem, n, k;
  logic [2:0] op_q;
  logic sign, accept, is_shift, is_rot;
  logic [WIDTH-1:0] stepped;
  always_comb begin
    is_shift = op == SHR || op == SHRA || op == SHL;
    is_rot   = op == ROR || op == ROL;
    n        = is_shift ? (shamt >= 32'(WIDTH) ? CNT_W'(WIDTH) : CNT_W'(shamt)) :
               is_rot   ? CNT_W'(shamt[LW-1:0]) : '0;
    k        = rem > CNT_W'(STEP) ? CNT_W'(STEP) : rem;
    accept   = start && state != SHIFT;
    state_n  = accept            ? (n != '0 ? SHIFT : DONE) :
               state == SHIFT    ? (rem == k ? DONE : SHIFT) :
               state == DONE     ? IDLE : state;
  end
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state  <= IDLE;
      rem    <= '0;
      op_q   <= '0;
      sign   <= 1'b0;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state <= state_n;
      busy  <= (state_n == SHIFT);
      done  <= (state_n == DONE);
      if (accept) begin
        result <= a;
        op_q   <= op;
        rem    <= n;
        sign   <= a[WIDTH-1];
      end else if (state == SHIFT) begin
        result <= stepped;
        rem    <= rem - k;
      end
    end
  end
  shift_step #(.WIDTH(WIDTH), .KW(CNT_W)) u_step (
    .value(result),
    .op(op_q),
    .k(k),
    .fill(sign && op_q == SHRA),
    .res(stepped)
  );
endmodule

// File: tb/tb_alu_shift_seq.sv
// tb_alu_shift_seq: directed scoreboard bench; STEP=1 unit checked fully, STEP=4 twin for busy length
module tb_alu_shift_seq;
  logic clock = 0, clear = 0, start = 0;
  logic [2:0] op = 0;
  logic [31:0] a = 0, shamt = 0;
  logic busy, done, busy4, done4;
  logic [31:0] result, result4;
  logic [31:0] q[$];
  int errors = 0, checks = 0, exp_n = 0, b4 = 0;
  logic [31:0] held;

  alu_shift_seq #(.WIDTH(32), .STEP(1)) u1 (
    .clock(clock), .clear(clear), .start(start), .op(op), .a(a), .shamt(shamt),
    .busy(busy), .done(done), .result(result));
  alu_shift_seq #(.WIDTH(32), .STEP(4)) u4 (
    .clock(clock), .clear(clear), .start(start), .op(op), .a(a), .shamt(shamt),
    .busy(busy4), .done(done4), .result(result4));

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [2:0] o, input logic [31:0] x,
                                input logic [31:0] s, output logic [31:0] r, output int n);
    case (o)
      3'd0, 3'd1, 3'd2: n = (s >= 32) ? 32 : int'(s);
      3'd3, 3'd4:       n = int'(s % 32);
      default:          n = 0;
    endcase
    case (o)
      3'd0:    r = (n == 32) ? 32'h0 : x >> n;
      3'd1:    r = (n == 32) ? {32{x[31]}} : 32'($signed(x) >>> n);
      3'd2:    r = (n == 32) ? 32'h0 : x << n;
      3'd3:    r = (n == 0) ? x : (x >> n) | (x << (32 - n));
      3'd4:    r = (n == 0) ? x : (x << n) | (x >> (32 - n));
      default: r = x;
    endcase
  endfunction

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] s);
    logic [31:0] r;
    int n;
    model(o, x, s, r, n);
    q.push_back(r);
    exp_n = n;
    @(negedge clock);
    start = 1; op = o; a = x; shamt = s;
    @(posedge clock); #1;
    start = 0;
  endtask

  task automatic wait_done(input string tag, input int c0, input int bb0);
    int c = c0, b = bb0;
    logic [31:0] e;
    b4 = 0;
    while (done !== 1'b1 && c < 200) begin
      if (busy === 1'b1) b++;
      if (busy4 === 1'b1) b4++;
      @(posedge clock); #1;
      c++;
    end
    chk({tag, " done"}, 32'(done), 32'd1);
    chk({tag, " latency"}, 32'(c), 32'(exp_n + 1));
    chk({tag, " busy cycles"}, 32'(b), 32'(exp_n));
    e = q.pop_front();
    chk({tag, " result"}, result, e);
  endtask

  initial begin
    #1 clear = 1;
    #1;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset result", result, 32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock) clear = 0;

    issue(3'd1, 32'h800000F0, 32'd4);
    wait_done("shra4", 1, 0);
    @(posedge clock); #1;
    chk("done pulse width", 32'(done), 32'd0);
    chk("idle busy", 32'(busy), 32'd0);

    issue(3'd3, 32'h00000001, 32'd33);
    wait_done("ror33", 1, 0);
    issue(3'd4, 32'h80000000, 32'd64);
    wait_done("rol64", 1, 0);

    issue(3'd2, 32'hFFFFFFFF, 32'd40);
    wait_done("shl40", 1, 0);
    chk("shl40 step4 busy", 32'(b4), 32'd8);
    chk("shl40 step4 result", result4, 32'h0);
    issue(3'd1, 32'h80000000, 32'd100);
    wait_done("shra100", 1, 0);

    issue(3'd0, 32'h12345678, 32'd0);
    wait_done("shr0", 1, 0);
    issue(3'd7, 32'hDEADBEEF, 32'd5);
    wait_done("illegal", 1, 0);

    issue(3'd0, 32'hF0F0F0F0, 32'd8);
    start = 1; op = 3'd2; a = 32'h11111111; shamt = 32'd3;
    @(posedge clock); #1;
    start = 0;
    wait_done("shr8 ignore", 2, 1);
    issue(3'd4, 32'h80000001, 32'd4);
    chk("b2b no bubble", 32'(busy), 32'd1);
    wait_done("b2b rol4", 1, 0);
    held = result;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      chk($sformatf("hold %0d", i), result, held);
    end

    issue(3'd1, 32'h80000000, 32'd20);
    void'(q.pop_back());
    repeat (3) @(posedge clock);
    #2;
    clear = 1; start = 1;
    #1;
    chk("async clear busy", 32'(busy), 32'd0);
    chk("async clear done", 32'(done), 32'd0);
    chk("async clear result", result, 32'd0);
    repeat (2) @(posedge clock); #1;
    chk("clear start ignored", 32'(busy | done), 32'd0);
    chk("clear hold result", result, 32'd0);
    @(negedge clock);
    clear = 0; start = 0;
    issue(3'd0, 32'h80000000, 32'd31);
    wait_done("post clear shr31", 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
